// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-side responder for CPU data accesses (word/half/byte
// loads and stores) in front of a word-wide synchronous RAM with fixed read latency.
// Sub-word stores are done as read-modify-write. Sub-word loads are extracted
// and extended to 32 bits.
//
// Optional build macro: LOAD_SIGN_EXT_EN
//   defined   -> byte/half loads are sign-extended
//   undefined -> byte/half loads are zero-extended
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   req/we/size     request (sampled in idle only), 1=store, 00/11 word 01 half 10 byte
//   addr/wdata      byte address, store data (sub-word taken from low bits)
//   ready/misalign  one-cycle completion pulse, rejected-access flag valid with ready
//   rdata           load result, valid with ready on loads, held otherwise
//   ram_addr        word-aligned RAM address
//   ram_wr          RAM write strobe
//   ram_wdata       RAM write data
//   ram_rdata       RAM read data, RAM_LAT cycles after ram_addr
module mem_access_ctrl #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RAM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              mis_q, mis_d;

  logic req_is_word;
  logic req_mis;

  // Size 11 is treated as a word access.
  assign req_is_word = (size == 2'b00) || (size == 2'b11);
  assign req_mis     = (req_is_word && (addr[1:0] != 2'b00)) || ((size == 2'b01) && addr[0]);

  function automatic logic [31:0] load_extract(logic [31:0] word, logic [1:0] sz,
                                               logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {a, 3'b000};
    case (sz)
`ifdef LOAD_SIGN_EXT_EN
      2'b10:   res = {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sh[15]}}, sh[15:0]};
`else
      2'b10:   res = {24'b0, sh[7:0]};
      2'b01:   res = {16'b0, sh[15:0]};
`endif
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half of word with the low bits of data.
  function automatic logic [31:0] store_merge(logic [31:0] word, logic [1:0] sz,
                                              logic [1:0] a, logic [15:0] data);
    logic [31:0] lane;
    logic [31:0] ins;
    lane = (sz == 2'b10) ? 32'h0000_00ff : 32'h0000_ffff;
    ins  = ({16'b0, data} & lane) << {a, 3'b000};
    lane = lane << {a, 3'b000};
    return (word & ~lane) | ins;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    mis_d       = mis_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          addr_lo_d  = addr[1:0];
          wdata_d    = wdata[15:0];
          ram_addr_d = {addr[31:2], 2'b00};
          cnt_d      = '0;
          mis_d      = req_mis;
          if (req_mis) begin
            state_d = StDone;
          end else if (we && req_is_word) begin
            state_d     = StWrite;
            ram_wdata_d = wdata;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == CntLast) begin
          if (we_q) begin
            state_d     = StWrite;
            ram_wdata_d = store_merge(ram_rdata, size_q, addr_lo_q, wdata_q);
          end else begin
            state_d = StDone;
            rdata_d = load_extract(ram_rdata, size_q, addr_lo_q);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrite: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        mis_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      mis_q       <= mis_d;
    end
  end

  assign ready     = (state_q == StDone);
  assign misalign  = ready & mis_q;
  assign ram_wr    = (state_q == StWrite);
  assign rdata     = rdata_q;
  assign ram_wdata = ram_wdata_q;
  // Address goes out in the accept cycle so the RAM read overlaps the accept;
  // gated by reset so every output is zero while reset is held.
  assign ram_addr  = (state_q == StIdle && req && reset) ? {addr[31:2], 2'b00} : ram_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with RAM_LAT=1 and one with RAM_LAT=3,
// each behind its own RAM model. Expected completions and RAM writes are queued
// when a request is driven and checked when the DUT reports them.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]  req_s, we_s, ready_s, misalign_s, ram_wr_s;
  logic [1:0]  size_s      [2];
  logic [31:0] addr_s      [2];
  logic [31:0] wdata_s     [2];
  logic [31:0] rdata_s     [2];
  logic [31:0] ram_addr_s  [2];
  logic [31:0] ram_wdata_s [2];
  logic [31:0] ram_rdata_s [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef LOAD_SIGN_EXT_EN
  localparam logic [31:0] ExpB80   = 32'hffff_ff80;
  localparam logic [31:0] ExpHcafe = 32'hffff_cafe;
  localparam logic [31:0] ExpBde   = 32'hffff_ffde;
`else
  localparam logic [31:0] ExpB80   = 32'h0000_0080;
  localparam logic [31:0] ExpHcafe = 32'h0000_cafe;
  localparam logic [31:0] ExpBde   = 32'h0000_00de;
`endif

  mem_access_ctrl #(.RAM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(rst_n), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
    .misalign(misalign_s[0]), .ram_addr(ram_addr_s[0]), .ram_wr(ram_wr_s[0]),
    .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0])
  );

  mem_access_ctrl #(.RAM_LAT(3)) u_dut_lat3 (
    .clk(clk), .reset(rst_n), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
    .misalign(misalign_s[1]), .ram_addr(ram_addr_s[1]), .ram_wr(ram_wr_s[1]),
    .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1])
  );

  // RAM models: read data appears RAM_LAT cycles after the address.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  always @(posedge clk) begin
    pipe0 <= mem0[ram_addr_s[0][7:2]];
    if (ram_wr_s[0] === 1'b1) mem0[ram_addr_s[0][7:2]] = ram_wdata_s[0];
    pipe1[0] <= mem1[ram_addr_s[1][7:2]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    if (ram_wr_s[1] === 1'b1) mem1[ram_addr_s[1][7:2]] = ram_wdata_s[1];
  end
  assign ram_rdata_s[0] = pipe0;
  assign ram_rdata_s[1] = pipe1[2];

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];
  exp_t mon_e;
  wr_t  mon_w;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready_s[d] === 1'b1) begin
        check_eq("ready_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("ready_dut", 32'(d), 32'(mon_e.d));
          check_eq("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
          check_eq("rdata", rdata_s[d], mon_e.rdata);
          check_eq("misalign", 32'(misalign_s[d]), 32'(mon_e.mis));
        end
      end
      if (ram_wr_s[d] === 1'b1) begin
        check_eq("ram_wr_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          mon_w = wq.pop_front();
          check_eq("wr_dut", 32'(d), 32'(mon_w.d));
          check_eq("wr_addr", ram_addr_s[d], mon_w.addr);
          check_eq("wr_data", ram_wdata_s[d], mon_w.data);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("ready_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic push_exp(input int d, input int c, input logic [31:0] rd, input logic mis);
    exp_t e;
    e.d = d; e.cyc = c; e.rdata = rd; e.mis = mis;
    sb.push_back(e);
  endtask

  // Drive one request in an idle cycle; lat is cycles from the accept cycle to ready.
  task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] exp_rd,
                       input logic exp_mis, input logic has_wr, input logic [31:0] exp_wr);
    wr_t wr;
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
    push_exp(d, cyc + lat, exp_rd, exp_mis);
    if (has_wr) begin
      wr.d = d; wr.addr = {a[31:2], 2'b00}; wr.data = exp_wr;
      wq.push_back(wr);
    end
    @(negedge clk);
    #1;
    req_s[d] = 1'b0;
    if (!exp_mis) check_eq("ram_addr", ram_addr_s[d], {a[31:2], 2'b00});
    wait_idle();
  endtask

  task automatic check_zero_outputs(input int d);
    check_eq("rst_ready", 32'(ready_s[d]), 32'd0);
    check_eq("rst_misalign", 32'(misalign_s[d]), 32'd0);
    check_eq("rst_ram_wr", 32'(ram_wr_s[d]), 32'd0);
    check_eq("rst_rdata", rdata_s[d], 32'd0);
    check_eq("rst_ram_addr", ram_addr_s[d], 32'd0);
    check_eq("rst_ram_wdata", ram_wdata_s[d], 32'd0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    req_s = '0;
    we_s  = '0;
    for (int d = 0; d < 2; d++) begin
      size_s[d] = 2'b00; addr_s[d] = '0; wdata_s[d] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 32'h0; mem1[i] = 32'h0;
    end
    mem0[4]  = 32'hcafe_babe;  // 0x10
    mem0[8]  = 32'h1234_5680;  // 0x20
    mem0[12] = 32'haabb_ccdd;  // 0x30
    mem1[24] = 32'h0102_0304;  // 0x60
    mem1[28] = 32'h5566_7788;  // 0x70
    mem1[29] = 32'h99aa_bbcc;  // 0x74

    #1;
    check_zero_outputs(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // RAM_LAT=1: load 2, sub-word store 3, word store 2, misaligned 1
    issue(0, 1'b0, 2'b00, 32'h10, 32'h0,        2, 32'hcafe_babe, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b0, 2'b10, 32'h20, 32'h0,        2, ExpB80,        1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 2'b01, 32'h32, 32'h0000_1122, 3, ExpB80,       1'b0, 1'b1, 32'h1122_ccdd);
    issue(0, 1'b0, 2'b00, 32'h41, 32'h0,        1, ExpB80,        1'b1, 1'b0, 32'h0);
    issue(0, 1'b0, 2'b01, 32'h22, 32'h0,        2, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b0, 2'b01, 32'h12, 32'h0,        2, ExpHcafe,      1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 2'b10, 32'h31, 32'hffff_ff77, 3, ExpHcafe,     1'b0, 1'b1, 32'h1122_77dd);
    issue(0, 1'b0, 2'b10, 32'h33, 32'h0,        2, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 2'b00, 32'h50, 32'hdead_beef, 2, 32'h0000_0011, 1'b0, 1'b1, 32'hdead_beef);
    issue(0, 1'b0, 2'b11, 32'h50, 32'h0,        2, 32'hdead_beef, 1'b0, 1'b0, 32'h0);
    issue(0, 1'b1, 2'b01, 32'h35, 32'h0000_5555, 1, 32'hdead_beef, 1'b1, 1'b0, 32'h0);
    issue(0, 1'b0, 2'b10, 32'h53, 32'h0,        2, ExpBde,        1'b0, 1'b0, 32'h0);
    check_eq("mem_0x30", mem0[12], 32'h1122_77dd);

    // Reset during the read phase of a byte store must abandon it.
    @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; size_s[1] = 2'b10; addr_s[1] = 32'h61;
    wdata_s[1] = 32'h0000_00aa;
    @(negedge clk);
    #1;
    req_s[1] = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs(1);
    check_zero_outputs(0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("mem_0x60_kept", mem1[24], 32'h0102_0304);
    issue(1, 1'b0, 2'b00, 32'h60, 32'h0, 4, 32'h0102_0304, 1'b0, 1'b0, 32'h0);

    // RAM_LAT=3 back-to-back loads with req held: second accept in the idle cycle after done.
    @(negedge clk);
    c = cyc;
    req_s[1] = 1'b1; we_s[1] = 1'b0; size_s[1] = 2'b00; addr_s[1] = 32'h70;
    push_exp(1, c + 4, 32'h5566_7788, 1'b0);
    @(negedge clk);
    #1;
    addr_s[1] = 32'h74;
    push_exp(1, c + 9, 32'h99aa_bbcc, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    req_s[1] = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    check_eq("writes_left", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side responder for the multicycle CPU's data accesses. Serves word, halfword and byte loads and stores.
- Drives a word-wide synchronous RAM with fixed read latency.
- Sub-word stores use read-modify-write; sub-word loads are extracted and extended.
- Sits between the CPU datapath/control and the word RAM; one request is outstanding at a time.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles (>=1) from ram_addr valid to ram_rdata valid.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request, sampled only in IDLE
- we  in  1  1=store, 0=load
- size  in  2  00=word, 01=halfword, 10=byte, 11=treated as word
- addr  in  32  byte address
- wdata  in  32  store data; byte/half taken from low bits
- ready  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid when ready=1 and we=0
- misalign  out  1  valid with ready; access rejected
- ram_addr  out  32  word-aligned RAM address {addr[31:2],2'b00}
- ram_wr  out  1  RAM write strobe
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. ready, misalign, ram_wr = 0. rdata, ram_addr, ram_wdata = 0. Counter cleared.
- Reset mid-operation abandons the access: ram_wr drops immediately and no partial write completes.
- Byte order is little-endian: addr[1:0]=0 selects bits 7:0; a halfword at addr[1]=0 is bits 15:0.
- State IDLE: when req=1, latch we/size/addr/wdata and drive ram_addr. Next state:
  - misaligned → DONE with misalign=1
  - word store → WRITE
  - otherwise → READ
- Misaligned means: size=01 with addr[0]=1, or word with addr[1:0]!=0. No RAM access is made.
- State READ: lasts exactly RAM_LAT cycles, counted by an internal counter. On its final edge, capture ram_rdata, then:
  - load → DONE, rdata updated
  - sub-word store → WRITE
- State WRITE: one cycle with ram_wr=1.
  - Word store: ram_wdata = wdata.
  - Sub-word store: ram_wdata = captured word with the addressed byte/half replaced by wdata[7:0]/wdata[15:0]; other bytes are unchanged.
  - Next state → DONE.
- State DONE: one cycle. ready=1. misalign=1 only for a rejected access. Next state → IDLE.
- Loads: byte/half zero-extended to 32 bits (see optional feature).
- Latency from the accept edge to the ready cycle:
  - misaligned: 1
  - word store: 2
  - load: RAM_LAT+1
  - sub-word store: RAM_LAT+2
- req is ignored outside IDLE. A req held through DONE is accepted at the next IDLE cycle, so the minimum gap between accepts is latency+1.
- rdata holds its last load value across stores and idle periods. It is not updated on misaligned loads.
- ram_addr holds after an operation. ram_wr is never 1 outside WRITE.

Optional Feature:
- Macro: LOAD_SIGN_EXT_EN.
- Defined: byte/half loads are sign-extended from bit 7/15.
- Undefined: byte/half loads are zero-extended.
- Word loads and all stores are identical in both builds.

Test Plan:
- Word load with RAM_LAT=1, RAM[0x10]=0xCAFEBABE, req at addr=0x10 → ram_addr=0x10; ready=1 exactly 2 cycles after accept; rdata=0xCAFEBABE; misalign=0.
- Byte load with RAM[0x20]=0x12345680, addr=0x20, size=10 → rdata=0x00000080. With LOAD_SIGN_EXT_EN defined → 0xFFFFFF80.
- Halfword store with RAM[0x30]=0xAABBCCDD, addr=0x32, size=01, wdata=0x00001122 → one ram_wr pulse with ram_wdata=0x1122CCDD; ready 3 cycles after accept.
- Misaligned word load at addr=0x41 → ready=1 and misalign=1 one cycle after accept; ram_wr never 1; rdata unchanged.
- Reset asserted (reset=0) during READ of a byte store → ram_wr stays 0, all outputs return to 0 immediately, RAM contents unchanged. After release, a new word load completes normally.
- RAM_LAT=3, back-to-back loads with req held high → first ready 4 cycles after accept; second accept occurs in the IDLE cycle after DONE.
